// File: rtl/nand_cpu_pkg.sv
// Shared types and defaults for the NAND CPU front end.
package nand_cpu_pkg;

   typedef enum logic [1:0] {
      FETCH_REQ,
      FETCH_ISSUE,
      FETCH_HALTED
   } fetch_state_e;

   localparam logic [15:0] ISR_BASE_DEFAULT = 16'h0010;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for a consumed instruction: redirect > interrupt > halt > sequential.
// The interrupt vector path exists only when NAND_CPU_INT_EN is defined.
module fetch_next_pc
   import nand_cpu_pkg::*;
#(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] ISR_BASE = PC_WIDTH'(ISR_BASE_DEFAULT)
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                dec_interrupt,
   input  logic [3:0]          dec_immdt,
   input  logic                dec_halt,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                take_int,
   output logic                go_halt
);

   logic [PC_WIDTH-1:0] seq_pc;
   logic [PC_WIDTH-1:0] vec_pc;

   assign seq_pc = pc + PC_WIDTH'(1);

`ifdef NAND_CPU_INT_EN
   assign take_int = ~redirect & dec_interrupt;
   assign vec_pc   = ISR_BASE + PC_WIDTH'(dec_immdt);
`else
   // INT decodes as an ordinary instruction, so its operands are don't-care here.
   logic unused_int;
   assign unused_int = ^{dec_interrupt, dec_immdt, ISR_BASE};
   assign take_int   = 1'b0;
   assign vec_pc     = seq_pc;
`endif

   always_comb begin
      next_pc = seq_pc;
      go_halt = 1'b0;
      if (redirect)
         next_pc = redirect_pc;
      else if (take_int)
         next_pc = vec_pc;
      else
         go_halt = dec_halt;
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, req/ack instruction read, issue to decoder, halted/EPC state.
// NAND_CPU_INT_EN enables the interrupt vector path and the EPC register.
module instr_fetch
   import nand_cpu_pkg::*;
#(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [PC_WIDTH-1:0] ISR_BASE = PC_WIDTH'(ISR_BASE_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [7:0]          imem_rdata,
   output logic                instr_valid,
   output logic [7:0]          instr,
   output logic [PC_WIDTH-1:0] pc,
   input  logic                stall,
   input  logic                redirect,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                dec_interrupt,
   input  logic [3:0]          dec_immdt,
   input  logic                dec_halt,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] epc,
   output logic                halted
);

   fetch_state_e        state, state_nxt;
   logic                consume;
   logic [PC_WIDTH-1:0] next_pc;
   logic                take_int;
   logic                go_halt;

   fetch_next_pc #(
      .PC_WIDTH (PC_WIDTH),
      .ISR_BASE (ISR_BASE)
   ) u_next_pc (
      .pc            (pc),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .dec_interrupt (dec_interrupt),
      .dec_immdt     (dec_immdt),
      .dec_halt      (dec_halt),
      .next_pc       (next_pc),
      .take_int      (take_int),
      .go_halt       (go_halt)
   );

   assign consume   = (state == FETCH_ISSUE) && !stall;
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst)
         state <= FETCH_REQ;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      case (state)
         FETCH_REQ: begin
            imem_req = 1'b1;
            if (imem_ack)
               state_nxt = FETCH_ISSUE;
         end
         FETCH_ISSUE: begin
            if (!stall)
               state_nxt = go_halt ? FETCH_HALTED : FETCH_REQ;
         end
         FETCH_HALTED: begin
            if (resume)
               state_nxt = FETCH_REQ;
         end
         default: state_nxt = FETCH_REQ;
      endcase
   end

   // Flags are registered copies of the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         instr       <= 8'h00;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         if (state == FETCH_REQ && imem_ack)
            instr <= imem_rdata;
         if (consume)
            pc <= next_pc;
         instr_valid <= (state_nxt == FETCH_ISSUE);
         halted      <= (state_nxt == FETCH_HALTED);
      end
   end

`ifdef NAND_CPU_INT_EN
   always_ff @(posedge clk) begin
      if (rst)
         epc <= '0;
      else if (consume && take_int)
         epc <= pc + PC_WIDTH'(1);
   end
`else
   logic unused_take_int;
   assign unused_take_int = take_int;
   assign epc             = '0;
`endif

endmodule
